// File: rtl/inst_fetch_pkg.sv
// Shared fetch/execute defines: FSM state encoding, cycle counter width, condition ops and PSR layout.
// Types only; no logic lives here.
package inst_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      EXEC   = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   // One counter serves both the ack timeout (up to 254) and the exec settle count (up to 14).
   localparam int CYC_W = 8;
   typedef logic [CYC_W-1:0] cyc_cnt_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_CS = 4'd2,
      COND_CC = 4'd3,
      COND_MI = 4'd4,
      COND_PL = 4'd5,
      COND_VS = 4'd6,
      COND_VC = 4'd7,
      COND_HI = 4'd8,
      COND_LS = 4'd9,
      COND_GE = 4'd10,
      COND_LT = 4'd11,
      COND_GT = 4'd12,
      COND_LE = 4'd13,
      COND_AL = 4'd14,
      COND_NV = 4'd15
   } cond_op_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } psr_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch/commit sequencer: IDLE -> FETCH (req held until ack, retried on timeout) -> EXEC (EXEC_CYCLES settle) -> commit.
// Commit strobe is combinational in the last EXEC cycle; stall holds commit, halt parks the FSM after the next commit.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          EXEC_CYCLES = 2,
   parameter int          ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        stall,
   input  logic        halt,
   input  logic [31:0] pcNext,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   output logic [31:0] instr,
   output logic [31:0] pcPlus1,
   output logic        pulse_en,
   output logic        fetchErr,
   output logic        halted
);

   localparam cyc_cnt_t EXEC_LAST = cyc_cnt_t'(EXEC_CYCLES - 1);
   localparam cyc_cnt_t ACK_LAST  = cyc_cnt_t'(ACK_TIMEOUT - 1);

   fetch_state_t state;
   logic [31:0]  pc;
   cyc_cnt_t     cyc_cnt;
   logic         commit;

   assign commit   = (state == EXEC) && (cyc_cnt == EXEC_LAST) && !stall;
   assign pulse_en = commit;
   assign imemAddr = pc;
   assign pcPlus1  = pc + 32'd1;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         instr    <= '0;
         cyc_cnt  <= '0;
         fetchErr <= 1'b0;
         imemReq  <= 1'b0;
         halted   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state   <= FETCH;
               imemReq <= 1'b1;
            end
            FETCH: begin
               if (imemAck) begin
                  instr   <= imemData;
                  cyc_cnt <= '0;
                  state   <= EXEC;
                  imemReq <= 1'b0;
               end else if (cyc_cnt == ACK_LAST) begin
                  // Timeout: flag it and keep the request up as a retry.
                  fetchErr <= 1'b1;
                  cyc_cnt  <= '0;
               end else begin
                  cyc_cnt <= cyc_cnt + cyc_cnt_t'(1);
               end
            end
            EXEC: begin
               if (commit) begin
                  pc      <= pcNext;
                  cyc_cnt <= '0;
                  if (halt) begin
                     state  <= HALTED;
                     halted <= 1'b1;
                  end else begin
                     state   <= FETCH;
                     imemReq <= 1'b1;
                  end
               end else if (!stall && (cyc_cnt != EXEC_LAST)) begin
                  cyc_cnt <= cyc_cnt + cyc_cnt_t'(1);
               end
            end
            HALTED: begin
               if (!halt) begin
                  state   <= FETCH;
                  halted  <= 1'b0;
                  imemReq <= 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               imemReq <= 1'b0;
               halted  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, basic fetch/commit, stall, ack timeout, halt, PC wrap, reset mid-exec.
module tb_inst_fetch;

   logic        clk;
   logic        clr_n;
   logic        stall;
   logic        halt;
   logic [31:0] pcNext;
   logic        imemAck;
   logic [31:0] imemData;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic [31:0] instr;
   logic [31:0] pcPlus1;
   logic        pulse_en;
   logic        fetchErr;
   logic        halted;

   int pass_cnt  = 0;
   int total_cnt = 0;

   inst_fetch dut (
      .clk      (clk),
      .clr_n    (clr_n),
      .stall    (stall),
      .halt     (halt),
      .pcNext   (pcNext),
      .imemAck  (imemAck),
      .imemData (imemData),
      .imemReq  (imemReq),
      .imemAddr (imemAddr),
      .instr    (instr),
      .pcPlus1  (pcPlus1),
      .pulse_en (pulse_en),
      .fetchErr (fetchErr),
      .halted   (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr_n = 1'b0; stall = 1'b0; halt = 1'b0;
      pcNext = '0; imemAck = 1'b0; imemData = '0;
      repeat (3) tick();
      total_cnt++; if (imemReq !== 1'b0) $display("FAIL reset_req: got %b want 0", imemReq); else pass_cnt++;
      total_cnt++; if (imemAddr !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", imemAddr); else pass_cnt++;
      total_cnt++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want 00000000", instr); else pass_cnt++;
      total_cnt++; if (pcPlus1 !== 32'h1) $display("FAIL reset_pcplus1: got %h want 00000001", pcPlus1); else pass_cnt++;
      total_cnt++; if ({pulse_en, fetchErr, halted} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {pulse_en, fetchErr, halted}); else pass_cnt++;
      clr_n = 1'b1;
      #1;
      total_cnt++; if (imemReq !== 1'b0) $display("FAIL idle_req: got %b want 0", imemReq); else pass_cnt++;
   endtask

   task automatic test_basic_fetch();
      tick(); // FETCH cycle 1
      total_cnt++; if (imemReq !== 1'b1) $display("FAIL fetch1_req: got %b want 1", imemReq); else pass_cnt++;
      total_cnt++; if (imemAddr !== 32'h0) $display("FAIL fetch1_addr: got %h want 00000000", imemAddr); else pass_cnt++;
      tick(); // FETCH cycle 2: ack now
      imemAck = 1'b1; imemData = 32'h1234_5678; pcNext = 32'd5;
      tick(); // EXEC cycle 1
      imemAck = 1'b0; imemData = 32'hFFFF_0000;
      total_cnt++; if (instr !== 32'h1234_5678) $display("FAIL basic_instr: got %h want 12345678", instr); else pass_cnt++;
      total_cnt++; if ({imemReq, pulse_en} !== 2'b00) $display("FAIL exec1_req_pulse: got %b want 00", {imemReq, pulse_en}); else pass_cnt++;
      tick(); // EXEC cycle 2 = commit
      total_cnt++; if (pulse_en !== 1'b1) $display("FAIL basic_commit_pulse: got %b want 1", pulse_en); else pass_cnt++;
      tick(); // back in FETCH
      total_cnt++; if (pulse_en !== 1'b0) $display("FAIL basic_pulse_once: got %b want 0", pulse_en); else pass_cnt++;
      total_cnt++; if (imemAddr !== 32'd5) $display("FAIL basic_next_addr: got %h want 00000005", imemAddr); else pass_cnt++;
      total_cnt++; if (instr !== 32'h1234_5678) $display("FAIL basic_instr_hold: got %h want 12345678", instr); else pass_cnt++;
   endtask

   task automatic test_stall();
      imemAck = 1'b1; imemData = 32'hA5A5_0001; pcNext = 32'd9;
      tick(); // EXEC cycle 1
      imemAck = 1'b0;
      tick(); // EXEC cycle 2, would commit without stall
      stall = 1'b1;
      #1;
      total_cnt++; if (pulse_en !== 1'b0) $display("FAIL stall_c1_pulse: got %b want 0", pulse_en); else pass_cnt++;
      tick();
      total_cnt++; if (pulse_en !== 1'b0) $display("FAIL stall_c2_pulse: got %b want 0", pulse_en); else pass_cnt++;
      total_cnt++; if (imemAddr !== 32'd5) $display("FAIL stall_pc_hold: got %h want 00000005", imemAddr); else pass_cnt++;
      tick();
      total_cnt++; if (pulse_en !== 1'b0) $display("FAIL stall_c3_pulse: got %b want 0", pulse_en); else pass_cnt++;
      tick();
      stall = 1'b0;
      #1;
      total_cnt++; if (pulse_en !== 1'b1) $display("FAIL stall_release_pulse: got %b want 1", pulse_en); else pass_cnt++;
      total_cnt++; if (instr !== 32'hA5A5_0001) $display("FAIL stall_instr: got %h want a5a50001", instr); else pass_cnt++;
      tick();
      total_cnt++; if (imemAddr !== 32'd9) $display("FAIL stall_next_addr: got %h want 00000009", imemAddr); else pass_cnt++;
   endtask

   task automatic test_timeout();
      int req_drops;
      req_drops = 0;
      // Currently in FETCH cycle 1 at pc 9, no ack.
      for (int i = 2; i <= 255; i++) begin
         tick();
         if (imemReq !== 1'b1) req_drops++;
      end
      total_cnt++; if (fetchErr !== 1'b0) $display("FAIL timeout_early: got %b want 0 at cycle 255", fetchErr); else pass_cnt++;
      tick(); // cycle 256
      total_cnt++; if (fetchErr !== 1'b1) $display("FAIL timeout_set: got %b want 1 at cycle 256", fetchErr); else pass_cnt++;
      for (int i = 257; i <= 300; i++) begin
         tick();
         if (imemReq !== 1'b1) req_drops++;
      end
      total_cnt++; if (req_drops !== 0) $display("FAIL timeout_req_held: got %0d drops want 0", req_drops); else pass_cnt++;
      total_cnt++; if (imemAddr !== 32'd9) $display("FAIL timeout_addr: got %h want 00000009", imemAddr); else pass_cnt++;
      imemAck = 1'b1; imemData = 32'hBEEF_0002; pcNext = 32'd20;
      tick(); // EXEC cycle 1
      imemAck = 1'b0;
      total_cnt++; if (instr !== 32'hBEEF_0002) $display("FAIL timeout_late_instr: got %h want beef0002", instr); else pass_cnt++;
      tick();
      total_cnt++; if (pulse_en !== 1'b1) $display("FAIL timeout_commit: got %b want 1", pulse_en); else pass_cnt++;
      tick();
      total_cnt++; if (imemAddr !== 32'd20) $display("FAIL timeout_next_addr: got %h want 00000014", imemAddr); else pass_cnt++;
      total_cnt++; if (fetchErr !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", fetchErr); else pass_cnt++;
   endtask

   task automatic test_halt();
      imemAck = 1'b1; imemData = 32'hC0DE_0003; pcNext = 32'd33; halt = 1'b1;
      tick(); // EXEC cycle 1
      imemAck = 1'b0;
      total_cnt++; if (halted !== 1'b0) $display("FAIL halt_early: got %b want 0", halted); else pass_cnt++;
      tick();
      total_cnt++; if (pulse_en !== 1'b1) $display("FAIL halt_commit: got %b want 1", pulse_en); else pass_cnt++;
      tick(); // HALTED
      total_cnt++; if ({halted, imemReq, pulse_en} !== 3'b100) $display("FAIL halt_state: got %b want 100", {halted, imemReq, pulse_en}); else pass_cnt++;
      total_cnt++; if (imemAddr !== 32'd33) $display("FAIL halt_pc: got %h want 00000021", imemAddr); else pass_cnt++;
      imemAck = 1'b1; imemData = 32'hDEAD_DEAD; pcNext = 32'd99;
      tick();
      imemAck = 1'b0;
      total_cnt++; if (instr !== 32'hC0DE_0003) $display("FAIL halt_ack_ignored: got %h want c0de0003", instr); else pass_cnt++;
      total_cnt++; if ({halted, imemAddr} !== {1'b1, 32'd33}) $display("FAIL halt_hold: got %b/%h want 1/00000021", halted, imemAddr); else pass_cnt++;
      halt = 1'b0;
      tick();
      total_cnt++; if ({halted, imemReq} !== 2'b01) $display("FAIL halt_resume: got %b want 01", {halted, imemReq}); else pass_cnt++;
      total_cnt++; if (imemAddr !== 32'd33) $display("FAIL halt_resume_addr: got %h want 00000021", imemAddr); else pass_cnt++;
   endtask

   task automatic test_pc_wrap();
      imemAck = 1'b1; imemData = 32'h0000_0004; pcNext = 32'hFFFF_FFFF;
      tick();
      imemAck = 1'b0;
      tick();
      tick(); // FETCH at FFFF_FFFF
      total_cnt++; if (imemAddr !== 32'hFFFF_FFFF) $display("FAIL wrap_addr: got %h want ffffffff", imemAddr); else pass_cnt++;
      total_cnt++; if (pcPlus1 !== 32'h0) $display("FAIL wrap_pcplus1: got %h want 00000000", pcPlus1); else pass_cnt++;
      imemAck = 1'b1; imemData = 32'h0000_0005; pcNext = pcPlus1;
      tick();
      imemAck = 1'b0;
      tick();
      tick();
      total_cnt++; if (imemAddr !== 32'h0) $display("FAIL wrap_next_addr: got %h want 00000000", imemAddr); else pass_cnt++;
      total_cnt++; if (pcPlus1 !== 32'h1) $display("FAIL wrap_next_pcplus1: got %h want 00000001", pcPlus1); else pass_cnt++;
   endtask

   task automatic test_reset_mid_exec();
      imemAck = 1'b1; imemData = 32'h7777_0006; pcNext = 32'd77;
      tick(); // EXEC cycle 1
      imemAck = 1'b0;
      total_cnt++; if (fetchErr !== 1'b1) $display("FAIL rst_pre_err: got %b want 1", fetchErr); else pass_cnt++;
      tick(); // EXEC cycle 2: reset before the commit edge
      clr_n = 1'b0;
      #1;
      total_cnt++; if (pulse_en !== 1'b0) $display("FAIL rst_no_pulse: got %b want 0", pulse_en); else pass_cnt++;
      total_cnt++; if (fetchErr !== 1'b0) $display("FAIL rst_err_clear: got %b want 0", fetchErr); else pass_cnt++;
      tick();
      total_cnt++; if ({imemReq, pulse_en, instr} !== {2'b00, 32'h0}) $display("FAIL rst_hold: got %b%b/%h want 00/00000000", imemReq, pulse_en, instr); else pass_cnt++;
      clr_n = 1'b1;
      tick();
      total_cnt++; if (imemAddr !== 32'h0) $display("FAIL rst_addr: got %h want 00000000", imemAddr); else pass_cnt++;
      total_cnt++; if ({imemReq, instr, fetchErr} !== {1'b1, 32'h0, 1'b0}) $display("FAIL rst_after: got %b/%h/%b want 1/00000000/0", imemReq, instr, fetchErr); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_stall();
      test_timeout();
      test_halt();
      test_pc_wrap();
      test_reset_mid_exec();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
